fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, address/data width.
REQ-002 SHALL have parameter RESET_PC, default 32'hbfc00000, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port stall  input  1  downstream hold; fetched instruction not consumed.
REQ-006 SHALL have ports br_taken  input  1 and br_target  input  WIDTH  for a branch/jump redirect.
REQ-007 SHALL have ports exc_flush  input  1 and exc_pc  input  WIDTH  for an exception/eret redirect.
REQ-008 SHALL have ports inst_req  output  1, inst_addr  output  WIDTH, inst_addr_ok  input  1, inst_data_ok  input  1, inst_rdata  input  WIDTH  for the instruction-memory handshake.
REQ-009 SHALL have ports pc_f  output  WIDTH, inst_f  output  WIDTH, inst_valid_f  output  1, fetch_busy  output  1.

Function
REQ-010 SHALL implement FSM states IDLE, WAIT_ADDR, WAIT_DATA, HOLD.
REQ-011 IDLE: SHALL assert inst_req with inst_addr=pc_f and move to WAIT_ADDR in the same cycle; inst_req is combinational from state.
REQ-012 WAIT_ADDR: SHALL hold inst_req=1 and inst_addr stable until inst_addr_ok=1, then go to WAIT_DATA; if inst_data_ok also=1 that cycle, treat as data return.
REQ-013 WAIT_DATA: SHALL keep inst_req=0; on inst_data_ok=1 capture inst_rdata into inst_f.
REQ-014 On a non-discarded data return with stall=0: SHALL assert inst_valid_f for exactly one cycle (the next cycle), set pc_f<=pc_f+4, return to IDLE.
REQ-015 On a non-discarded data return with stall=1: SHALL go to HOLD, keep inst_f, inst_valid_f=1 and pc_f unchanged until stall=0, then pc_f<=pc_f+4, go to IDLE.
REQ-016 pc_f+4 SHALL wrap modulo 2^WIDTH.
REQ-017 Redirect in IDLE or HOLD: SHALL load pc_f with the target next cycle, drop any held instruction (inst_valid_f=0), go to IDLE.
REQ-018 Redirect in WAIT_ADDR/WAIT_DATA: SHALL store target in a pending register, set a discard flag, complete the outstanding handshake, drop the returned data, then load pc_f with the pending target and go to IDLE.
REQ-019 exc_flush SHALL take priority over br_taken in the same cycle; a pending exception SHALL NOT be overwritten by a later branch; a pending branch SHALL be overwritten by a later exception.
REQ-020 Redirects SHALL be honoured regardless of stall.
REQ-021 fetch_busy SHALL be 1 whenever inst_valid_f=0 and not in reset.

Reset
REQ-022 On rst=1 at a clock edge: pc_f=RESET_PC, state=IDLE, inst_f=0, inst_valid_f=0, pending/discard cleared; inst_req=0 while rst=1.
REQ-023 Reset mid-handshake SHALL abandon the transaction; no stale data return is accepted after reset.

Configuration
REQ-024 Macro FETCH_ALIGN_CHECK_EN: when defined, SHALL add output adel_f (1 bit); if pc_f[1:0]!=0 in IDLE, no request issued, adel_f=1 and inst_valid_f=1 with inst_f=0 until a redirect.
REQ-025 Without FETCH_ALIGN_CHECK_EN: no adel_f port; requests issued regardless of alignment.

Structure
REQ-026 Package fetch_pkg SHALL hold the FSM state typedef, RESET_PC default and PC increment constant 4.
REQ-027 Sub-module fetch_redirect_buf SHALL hold the pending target, priority tag and discard flag.

Verification
REQ-028 Reset release, addr_ok and data_ok immediate -> first inst_addr=0xbfc00000, then 0xbfc00004, inst_valid_f one pulse per fetch.
REQ-029 stall=1 for 3 cycles at data return -> inst_valid_f held 3+ cycles, pc_f constant, no new inst_req.
REQ-030 br_taken target 0x80001000 during WAIT_DATA -> returned word dropped, next inst_addr=0x80001000.
REQ-031 br_taken=1 and exc_flush=1 same cycle (0x80001000 / 0xbfc00380) -> next inst_addr=0xbfc00380.
REQ-032 pc_f=0xfffffffc, normal fetch -> next inst_addr=0x00000000.
REQ-033 With FETCH_ALIGN_CHECK_EN, branch to 0x80000002 -> no inst_req, adel_f=1 until exc_flush.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: FSM state type and constants shared by the instruction fetch controller
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_ADDR, WAIT_DATA, HOLD} state_t;
  localparam logic [31:0] RESET_PC_DEF = 32'hbfc00000;
  localparam int unsigned PC_INC = 4;
endpackage

// File: rtl/fetch_redirect_buf.sv
// fetch_redirect_buf: parks a redirect target while a memory transaction drains; exceptions outrank branches
module fetch_redirect_buf
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             clr,
  input  logic             exc_flush,
  input  logic [WIDTH-1:0] exc_pc,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  output logic             redir,
  output logic [WIDTH-1:0] tgt
);
  logic [WIDTH-1:0] pend_tgt;
  logic pend_exc, discard, br_win;
  assign br_win = br_taken && !(discard && pend_exc);
  assign redir = exc_flush || br_taken || discard;
  assign tgt = exc_flush ? exc_pc : br_win ? br_target : pend_tgt;
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      discard <= 1'b0;
      pend_exc <= 1'b0;
      pend_tgt <= '0;
    end else if (ld) begin
      discard <= 1'b1;
      pend_exc <= exc_flush || (discard && pend_exc);
      pend_tgt <= tgt;
    end
  end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch FSM with branch/exception redirect; FETCH_ALIGN_CHECK_EN adds adel_f misaligned-PC trap
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             exc_flush,
  input  logic [WIDTH-1:0] exc_pc,
  output logic             inst_req,
  output logic [WIDTH-1:0] inst_addr,
  input  logic             inst_addr_ok,
  input  logic             inst_data_ok,
  input  logic [WIDTH-1:0] inst_rdata,
  output logic [WIDTH-1:0] pc_f,
  output logic [WIDTH-1:0] inst_f,
  output logic             inst_valid_f,
  output logic             fetch_busy
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic             adel_f
`endif
);
  state_t state;
  logic mis, acc, ret, open, redir;
  logic [WIDTH-1:0] tgt, pc_nxt;
`ifdef FETCH_ALIGN_CHECK_EN
  assign mis = pc_f[1:0] != 2'b00;
  assign adel_f = !rst && state == IDLE && mis;
`else
  assign mis = 1'b0;
`endif
  assign inst_req = !rst && ((state == IDLE && !mis) || state == WAIT_ADDR);
  assign inst_addr = pc_f;
  assign acc = inst_req && inst_addr_ok;
  assign ret = inst_data_ok && (acc || state == WAIT_DATA);
  // a transaction is open once the address is accepted (or WAIT_ADDR is committed) until data returns
  assign open = (state == WAIT_ADDR || state == WAIT_DATA || acc) && !ret;
  assign pc_nxt = pc_f + WIDTH'(PC_INC);
  assign fetch_busy = !rst && !inst_valid_f;
  fetch_redirect_buf #(.WIDTH(WIDTH)) u_rbuf (
    .clk(clk),
    .rst(rst),
    .ld(redir && open),
    .clr(redir && !open),
    .exc_flush(exc_flush),
    .exc_pc(exc_pc),
    .br_taken(br_taken),
    .br_target(br_target),
    .redir(redir),
    .tgt(tgt)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc_f <= RESET_PC;
      inst_f <= '0;
      inst_valid_f <= 1'b0;
    end else if (redir && !open) begin
      state <= IDLE;
      pc_f <= tgt;
      inst_valid_f <= 1'b0;
    end else if (redir) begin
      state <= acc ? WAIT_DATA : state;
      inst_valid_f <= 1'b0;
    end else if (ret) begin
      state <= stall ? HOLD : IDLE;
      pc_f <= stall ? pc_f : pc_nxt;
      inst_f <= inst_rdata;
      inst_valid_f <= 1'b1;
    end else if (state == HOLD) begin
      state <= stall ? HOLD : IDLE;
      pc_f <= stall ? pc_f : pc_nxt;
      inst_valid_f <= stall;
    end else begin
      state <= acc ? WAIT_DATA : (state == IDLE && !mis) ? WAIT_ADDR : state;
      inst_valid_f <= mis && state == IDLE;
      inst_f <= (mis && state == IDLE) ? {WIDTH{1'b0}} : inst_f;
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: scoreboard bench; accepted addresses and consumed instructions are checked against queued expectations
module tb_fetch_ctrl;
  logic clk = 0, rst, stall, br_taken, exc_flush;
  logic [31:0] br_target, exc_pc;
  logic inst_req, inst_valid_f, fetch_busy;
  logic [31:0] inst_addr, pc_f, inst_f;
  logic inst_addr_ok = 0, inst_data_ok = 0;
  logic [31:0] inst_rdata = 0;
`ifdef FETCH_ALIGN_CHECK_EN
  logic adel_f;
`endif
  int n_chk = 0, n_fail = 0;
  int given = 0, used = 0, dlat = 0, cnt = 0;
  bit busy = 0;
  logic [31:0] maddr = 0;
  logic [31:0] addr_q[$], inst_q[$];

  fetch_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall),
    .br_taken(br_taken), .br_target(br_target),
    .exc_flush(exc_flush), .exc_pc(exc_pc),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .pc_f(pc_f), .inst_f(inst_f), .inst_valid_f(inst_valid_f), .fetch_busy(fetch_busy)
`ifdef FETCH_ALIGN_CHECK_EN
    , .adel_f(adel_f)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic give(input int n, input int lat);
    given += n;
    dlat = lat;
  endtask

  task automatic ea(input logic [31:0] a);
    addr_q.push_back(a);
  endtask

  task automatic ei(input logic [31:0] d);
    inst_q.push_back(d);
  endtask

  task automatic drain();
    int k = 0;
    while ((addr_q.size() != 0 || inst_q.size() != 0) && k < 60) begin
      @(negedge clk); #4;
      k++;
    end
    check("drain", 32'(addr_q.size() + inst_q.size()), 0);
  endtask

  task automatic wait_valid(input int n);
    int k = 0;
    while (!inst_valid_f && k < n) begin
      @(negedge clk); #3;
      k++;
    end
    check("valid_timeout", {31'b0, inst_valid_f}, 1);
  endtask

  // memory: one outstanding transaction, word at address a reads back as ~a
  always @(negedge clk) begin
    #1;
    inst_data_ok = 0;
    inst_addr_ok = (used < given) && inst_req && !busy;
    if (busy) begin
      if (cnt == 0) begin
        inst_data_ok = 1;
        inst_rdata = ~maddr;
        busy = 0;
      end else cnt--;
    end else if (inst_addr_ok) begin
      used++;
      if (dlat == 0) begin
        inst_data_ok = 1;
        inst_rdata = ~inst_addr;
      end else begin
        busy = 1;
        cnt = dlat - 1;
        maddr = inst_addr;
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] e;
    #2;
    if (inst_req && inst_addr_ok) begin
      e = addr_q.size() != 0 ? addr_q.pop_front() : 32'hdeadbeef;
      check("inst_addr", inst_addr, e);
    end
    if (inst_valid_f && !stall) begin
      e = inst_q.size() != 0 ? inst_q.pop_front() : 32'hdeadbeef;
      check("inst_f", inst_f, e);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; stall = 0; br_taken = 0; exc_flush = 0; br_target = 0; exc_pc = 0;
    repeat (3) @(negedge clk);
    #3;
    check("rst_pc", pc_f, 32'hbfc00000);
    check("rst_req", {31'b0, inst_req}, 0);
    check("rst_valid", {31'b0, inst_valid_f}, 0);
    check("rst_inst", inst_f, 0);
    check("rst_busy", {31'b0, fetch_busy}, 0);
    // back-to-back fetches with zero-latency memory
    @(negedge clk); rst = 0; give(3, 0);
    ea(32'hbfc00000); ea(32'hbfc00004); ea(32'hbfc00008);
    ei(32'h403fffff); ei(32'h403ffffb); ei(32'h403ffff7);
    drain();
    @(negedge clk); #3;
    check("pulse_end", {31'b0, inst_valid_f}, 0);
    check("busy_idle", {31'b0, fetch_busy}, 1);
    // stall at data return
    @(negedge clk); stall = 1; give(1, 2); ea(32'hbfc0000c); ei(32'h403ffff3);
    wait_valid(20);
    repeat (3) begin
      check("hold_valid", {31'b0, inst_valid_f}, 1);
      check("hold_pc", pc_f, 32'hbfc0000c);
      check("hold_req", {31'b0, inst_req}, 0);
      check("hold_inst", inst_f, 32'h403ffff3);
      @(negedge clk); #3;
    end
    @(negedge clk); stall = 0;
    drain();
    // branch during WAIT_DATA drops the returned word
    @(negedge clk); give(1, 3); ea(32'hbfc00010);
    @(negedge clk); br_taken = 1; br_target = 32'h80001000;
    @(negedge clk); br_taken = 0; give(1, 0); ea(32'h80001000); ei(32'h7fffefff);
    drain();
    // simultaneous exc/br, then a later branch must not displace the pending exception
    @(negedge clk); br_taken = 1; br_target = 32'h80001000; exc_flush = 1; exc_pc = 32'hbfc00380;
    @(negedge clk); exc_flush = 0; br_target = 32'h80002000;
    @(negedge clk); br_taken = 0; give(2, 1);
    ea(32'h80001004); ea(32'hbfc00380); ei(32'h403ffc7f);
    drain();
    // pending branch replaced by a later exception
    @(negedge clk); br_taken = 1; br_target = 32'h80003000;
    @(negedge clk); br_taken = 0; exc_flush = 1; exc_pc = 32'h80000180;
    @(negedge clk); exc_flush = 0; give(2, 0);
    ea(32'hbfc00384); ea(32'h80000180); ei(32'h7ffffe7f);
    drain();
    // PC wraps past the top of the address space
    @(negedge clk); exc_flush = 1; exc_pc = 32'hfffffffc; give(3, 0);
    ea(32'h80000184); ea(32'hfffffffc); ea(32'h00000000);
    ei(32'h00000003); ei(32'hffffffff);
    @(negedge clk); exc_flush = 0;
    drain();
    // redirect while holding under stall
    @(negedge clk); stall = 1; give(1, 0); ea(32'h00000004);
    @(negedge clk); br_taken = 1; br_target = 32'h80001000;
    #3;
    check("held_before_br", {31'b0, inst_valid_f}, 1);
    @(negedge clk); br_taken = 0; stall = 0; give(1, 0); ea(32'h80001000); ei(32'h7fffefff);
    #3;
    check("br_hold_valid", {31'b0, inst_valid_f}, 0);
    check("br_hold_pc", pc_f, 32'h80001000);
    check("br_hold_busy", {31'b0, fetch_busy}, 1);
    drain();
    // reset mid-transaction; the stale return must be ignored
    @(negedge clk); give(1, 3); ea(32'h80001004);
    @(negedge clk); rst = 1;
    @(negedge clk); #3;
    check("rst2_pc", pc_f, 32'hbfc00000);
    check("rst2_req", {31'b0, inst_req}, 0);
    check("rst2_valid", {31'b0, inst_valid_f}, 0);
    @(negedge clk); rst = 0; give(1, 3); ea(32'hbfc00000); ei(32'h403fffff);
    drain();
`ifdef FETCH_ALIGN_CHECK_EN
    @(negedge clk); stall = 1; br_taken = 1; br_target = 32'h80000002; give(1, 0); ea(32'hbfc00004);
    @(negedge clk); br_taken = 0;
    @(negedge clk); #3;
    check("adel_set", {31'b0, adel_f}, 1);
    check("adel_noreq", {31'b0, inst_req}, 0);
    check("adel_valid", {31'b0, inst_valid_f}, 1);
    check("adel_inst", inst_f, 0);
    @(negedge clk); exc_flush = 1; exc_pc = 32'hbfc00380;
    @(negedge clk); exc_flush = 0; stall = 0; give(1, 0); ea(32'hbfc00380); ei(32'h403ffc7f);
    #3;
    check("adel_clear", {31'b0, adel_f}, 0);
    drain();
`else
    @(negedge clk); br_taken = 1; br_target = 32'h80000002; give(2, 0);
    ea(32'hbfc00004); ea(32'h80000002); ei(32'h7ffffffd);
    @(negedge clk); br_taken = 0;
    drain();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
